// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept time and held pending until the fixed latency expires.
module ex_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // Handshake: start is accepted only while busy=0. A start seen while busy=1
  // is dropped, not queued; md_stall tells the hazard unit to hold EX instead.
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den_s, den_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  assign a_mag = A[31] ? -A : A;
  assign b_mag = B[31] ? -B : B;
  assign den_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign den_u = (B == 32'd0) ? 32'd1 : B;
  assign q_mag = a_mag / den_s;
  assign r_mag = a_mag % den_s;
  assign q_s   = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign r_s   = A[31] ? -r_mag : r_mag;
  assign q_u   = A / den_u;
  assign r_u   = A % den_u;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            3'd1: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            3'd2: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              pend_wr_d = (B != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            3'd3: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              pend_wr_d = (B != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign md_stall = busy | (start & ~md_op[2]);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: arithmetic, latency, MTHI/MTLO,
// divide-by-zero, ignored start while busy, and asynchronous reset mid-divide.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, md_stall;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_errs   = 0;

  ex_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one cycle; md_stall is checked in that cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    #1;
    check32("md_stall_start", {31'd0, md_stall}, (op <= 3'd3) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  // Count busy cycles after an accepted start; optionally inject a MULT 5*6 at busy cycle inj.
  task automatic wait_busy(input int inj, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == inj) begin
        start = 1'b1; md_op = 3'd0; A = 32'd5; B = 32'd6;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check32("busy_done", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;

  vec_t vecs[8];
  int   n;
  logic any_bad;

  initial begin
    vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_stall", {31'd0, md_stall}, 32'd0);
    check32("rst_hi", HI, 32'd0);
    check32("rst_lo", LO, 32'd0);
    reset = 1'b0;

    // Arithmetic vectors with latency
    foreach (vecs[k]) begin
      do_op(vecs[k].op, vecs[k].a, vecs[k].b);
      wait_busy(-1, n);
      check32($sformatf("v%0d_cycles", k), n, vecs[k].n);
      check32($sformatf("v%0d_hi", k), HI, vecs[k].hi);
      check32($sformatf("v%0d_lo", k), LO, vecs[k].lo);
    end

    // MTHI then MTLO: one-cycle latency, never busy
    do_op(3'd4, 32'h12345678, 32'd0);
    check32("mthi_hi", HI, 32'h12345678);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    do_op(3'd5, 32'h9ABCDEF0, 32'd0);
    check32("mtlo_lo", LO, 32'h9ABCDEF0);
    check32("mtlo_hi", HI, 32'h12345678);
    check32("mtlo_busy", {31'd0, busy}, 32'd0);

    // Reserved op is a no-op
    do_op(3'd6, 32'hDEADBEEF, 32'd1);
    check32("rsv_busy", {31'd0, busy}, 32'd0);
    check32("rsv_hi", HI, 32'h12345678);
    check32("rsv_lo", LO, 32'h9ABCDEF0);

    // Divide by zero leaves HI/LO untouched after a full busy period
    do_op(3'd4, 32'h11, 32'd0);
    do_op(3'd5, 32'h22, 32'd0);
    do_op(3'd2, 32'd1234, 32'd0);
    wait_busy(-1, n);
    check32("div0_cycles", n, 32'd10);
    check32("div0_hi", HI, 32'h11);
    check32("div0_lo", LO, 32'h22);
    do_op(3'd3, 32'd99, 32'd0);
    wait_busy(-1, n);
    check32("divu0_hi", HI, 32'h11);
    check32("divu0_lo", LO, 32'h22);

    // Start during busy is ignored
    do_op(3'd0, 32'd3, 32'd4);
    #1 check32("busy_stall", {31'd0, md_stall}, 32'd1);
    wait_busy(2, n);
    check32("ign_cycles", n, 32'd5);
    check32("ign_lo", LO, 32'd12);
    check32("ign_hi", HI, 32'd0);
    @(negedge clk);
    check32("ign_no_queue", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a divide
    do_op(3'd4, 32'h55, 32'd0);
    do_op(3'd5, 32'h66, 32'd0);
    do_op(3'd2, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    check32("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("arst_busy", {31'd0, busy}, 32'd0);
    check32("arst_hi", HI, 32'd0);
    check32("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    any_bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy || HI != 32'd0 || LO != 32'd0) any_bad = 1'b1;
    end
    check32("post_rst_quiet", {31'd0, any_bad}, 32'd0);
    do_op(3'd0, 32'd2, 32'd2);
    wait_busy(-1, n);
    check32("post_rst_cycles", n, 32'd5);
    check32("post_rst_lo", LO, 32'd4);
    check32("post_rst_hi", HI, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
